// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: RISC-V immediate extraction and extension behind a
// valid/ready interface. The block holds two entries: an output register (OUT)
// and a skid register (SKID). This lets in_ready depend only on registered
// state while still sustaining one transfer per cycle.
module imm_extend_pipe #(
  parameter int XLEN = 32,  // 32 or 64
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:7]     Instr,
  input  logic [2:0]      ImmSrc,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ImmExt,
  output logic            Illegal,
  output logic [TAGW-1:0] out_tag
);

  typedef enum logic [2:0] {
    SRC_I     = 3'b000,
    SRC_S     = 3'b001,
    SRC_B     = 3'b010,
    SRC_J     = 3'b011,
    SRC_U     = 3'b100,
    SRC_SHAMT = 3'b101
  } imm_src_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic            illegal;
    logic [TAGW-1:0] tag;
  } entry_t;

  entry_t     new_entry;
  logic [31:0] imm32;
  logic        illegal_src;

  entry_t out_q, out_d;
  entry_t skid_q, skid_d;
  logic   out_valid_q, out_valid_d;
  logic   skid_valid_q, skid_valid_d;

  logic accept;
  logic out_free;

  // Decode the 32-bit immediate for the requested format.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    imm32       = '0;
    illegal_src = 1'b0;
    case (ImmSrc)
      SRC_I:     imm32 = {{20{Instr[31]}}, Instr[31:20]};
      SRC_S:     imm32 = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
      SRC_B:     imm32 = {{19{Instr[31]}}, Instr[31], Instr[7], Instr[30:25],
                          Instr[11:8], 1'b0};
      SRC_J:     imm32 = {{11{Instr[31]}}, Instr[31], Instr[19:12], Instr[20],
                          Instr[30:21], 1'b0};
      SRC_U:     imm32 = {Instr[31:12], 12'b0};
      SRC_SHAMT: imm32 = (XLEN == 64) ? {26'b0, Instr[25:20]}
                                      : {27'b0, Instr[24:20]};
      default:   illegal_src = 1'b1;
    endcase
  end

  // Widen to XLEN: every format is sign-extended from bit 31. SHAMT already
  // has bit 31 clear, so the same extension zero-extends it.
  assign new_entry.imm     = XLEN'($signed(imm32));
  assign new_entry.illegal = illegal_src;
  assign new_entry.tag     = in_tag;

  // SKID valid means both entries are full, so it alone gates acceptance.
  assign in_ready = !skid_valid_q && !reset;
  assign accept   = in_valid && in_ready;
  assign out_free = !out_valid_q || out_ready;

  // Next-state logic for the two-entry skid buffer.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (out_free) begin
      if (skid_valid_q) begin
        // in_ready is low this cycle, so nothing new can arrive.
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = new_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = new_entry;
      skid_valid_d = 1'b1;
    end
  end

  // Register the buffer state; reset discards everything buffered.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the data registers are reset as well, because ImmExt, Illegal
      // and out_tag must read zero straight out of reset.
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ImmExt    = out_q.imm;
  assign Illegal   = out_q.illegal;
  assign out_tag   = out_q.tag;

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width; legal values 32 and 64 only.
REQ-002 SHALL have parameter TAGW, default 5, width of the sideband tag carried with each request.
REQ-003 SHALL have one clock and reset; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  request present on Instr/ImmSrc/in_tag.
REQ-007 in_ready  output  1  block accepts a request this cycle.
REQ-008 Instr  input  [31:7]  instruction bits 31..7.
REQ-009 ImmSrc  input  3  format select: 000 I, 001 S, 010 B, 011 J, 100 U, 101 SHAMT, 110/111 illegal.
REQ-010 in_tag  input  TAGW  opaque sideband (e.g. rd index), returned unchanged.
REQ-011 out_valid  output  1  result present on ImmExt/Illegal/out_tag.
REQ-012 out_ready  input  1  consumer takes the result this cycle.
REQ-013 ImmExt  output  XLEN  extended immediate.
REQ-014 Illegal  output  1  result came from an illegal ImmSrc.
REQ-015 out_tag  output  TAGW  tag of the current result.

Function
REQ-016 Input transfer SHALL occur on in_valid && in_ready; output transfer on out_valid && out_ready.
REQ-017 Immediates, sign bit Instr[31] replicated to XLEN: I = Instr[31:20]; S = {Instr[31:25],Instr[11:7]}; B = {Instr[31],Instr[7],Instr[30:25],Instr[11:8],0}; J = {Instr[31],Instr[19:12],Instr[20],Instr[30:21],0}; U = {Instr[31:12],12'b0}, sign-extended above bit 31 when XLEN=64.
REQ-018 SHAMT SHALL zero-extend Instr[24:20] when XLEN=32, Instr[25:20] when XLEN=64.
REQ-019 Illegal ImmSrc SHALL produce ImmExt = 0 and Illegal = 1; all legal formats produce Illegal = 0.
REQ-020 Storage SHALL be a 2-entry skid buffer: output register (OUT) plus skid register (SKID), each with a valid bit.
REQ-021 Latency SHALL be exactly 1 cycle: an accepted request appears on outputs the next cycle when OUT is empty or being drained.
REQ-022 Throughput SHALL be 1 transfer per cycle while out_ready is held high.
REQ-023 in_ready SHALL equal !SKID.valid && !reset, combinational from registered state only (no path from out_ready).
REQ-024 Accept while OUT valid and not draining: the request SHALL load SKID.
REQ-025 OUT draining with SKID valid: SKID SHALL move to OUT and SKID.valid clear; a new request cannot arrive that cycle (in_ready = 0).
REQ-026 OUT draining, SKID empty, simultaneous accept: new result SHALL load OUT; out_valid stays 1.
REQ-027 OUT draining, no accept: out_valid SHALL clear.
REQ-028 Results SHALL leave in acceptance order; none dropped or duplicated.
REQ-029 ImmExt/Illegal/out_tag SHALL hold stable while out_valid && !out_ready.
REQ-030 Inputs with in_valid = 0 SHALL not change state.

Reset
REQ-031 On a reset edge, OUT.valid and SKID.valid SHALL clear; ImmExt = 0, Illegal = 0, out_tag = 0, out_valid = 0.
REQ-032 in_ready SHALL be 0 while reset is high and 1 on the first cycle after.
REQ-033 Reset mid-operation SHALL discard all buffered results regardless of out_ready.

Verification
REQ-034 I-type: Instr=0xFFF00093>>7, ImmSrc=000, out_ready=1 -> next cycle out_valid=1, ImmExt=0xFFFFFFFF, Illegal=0.
REQ-035 B/J/U: 0x00000463 B -> 0x00000008; 0xFFDFF06F J -> 0xFFFFFFFC; 0x12345037 U -> 0x12345000; XLEN=64, 0x80000037 U -> 0xFFFFFFFF80000000.
REQ-036 Backpressure: out_ready=0, push tags 1,2 -> in_ready=0 after second accept, third held; raise out_ready -> tags 1,2,3 emerge on consecutive cycles in order.
REQ-037 Illegal: ImmSrc=111, tag=9 -> ImmExt=0, Illegal=1, out_tag=9; SHAMT XLEN=32, Instr[24:20]=31 with Instr[31]=1 -> ImmExt=0x0000001F.
REQ-038 Reset mid-op: OUT and SKID full, out_ready=0, assert reset 1 cycle -> out_valid=0, ImmExt=0, in_ready=0 during reset, 1 the cycle after.
